// File: rtl/mmio_uart_fifo.sv
// Memory-mapped buffered UART: TX/RX FIFOs, programmable divisor, sticky errors, level irq.
// Define MMIO_UART_PARITY_EN for 8E1 frames with even parity; the default build is 8N1.
module mmio_uart_fifo #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(32'h1001_0020),
  parameter int                    FIFO_DEPTH   = 8,
  parameter int                    CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  input  logic                  MemWrite_i,
  input  logic                  MemRead_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  Hit_o,
  input  logic                  rx_pin,
  output logic                  tx_pin,
  output logic                  irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic [1:0]  reg_sel;
  logic        wr_en, rd_en, flush, clr_sticky;
  logic        ctrl_rx_irq, ctrl_tx_irq;
  logic [15:0] divisor;
  logic        rx_overrun, frame_err, parity_err;
  logic        set_overrun, set_frame_err, set_parity_err;
  logic        unused_bits;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]   tx_count;
  logic          tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0]    tx_head;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   rx_count;
  logic          rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0]    rx_head;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_par, tx_par_n, tx_bit_end;

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_prev, rx_bit_end, rx_half_end;

  logic [31:0] rdata;

  assign Hit_o      = (Address_i[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
  assign reg_sel    = Address_i[3:2];
  assign wr_en      = Hit_o & MemWrite_i;
  assign rd_en      = Hit_o & MemRead_i;
  assign tx_push    = wr_en && (reg_sel == 2'd0) && !tx_full;
  assign rx_pop     = rd_en && (reg_sel == 2'd0) && !rx_empty;
  assign flush      = wr_en && (reg_sel == 2'd2) && WriteData_i[3];
  assign clr_sticky = wr_en && (reg_sel == 2'd2) && WriteData_i[2];
  assign unused_bits = ^{WriteData_i, Address_i[1:0]};

  // Control, divisor and sticky flags; a new error in the clearing cycle still sticks
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_rx_irq <= 1'b0;
      ctrl_tx_irq <= 1'b0;
      divisor     <= 16'(CLKS_PER_BIT);
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      if (wr_en && reg_sel == 2'd2) begin
        ctrl_rx_irq <= WriteData_i[0];
        ctrl_tx_irq <= WriteData_i[1];
      end
      if (wr_en && reg_sel == 2'd3)
        divisor <= (WriteData_i[15:0] < 16'd2) ? 16'd2 : WriteData_i[15:0];
      if (clr_sticky) begin
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (set_overrun)    rx_overrun <= 1'b1;
      if (set_frame_err)  frame_err  <= 1'b1;
      if (set_parity_err) parity_err <= 1'b1;
    end
  end

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_head  = tx_mem[tx_rd_ptr];
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= WriteData_i[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // Flush only rewinds pointers; engines mid-frame are left alone
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= 16'd2;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
    end
  end

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_par_n   = ^tx_head;
          tx_div_n   = divisor;
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            tx_state_n = TX_PARITY;
`else
            tx_state_n = TX_STOP;
`endif
          end
        end
      end
      TX_PARITY: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START:  tx_pin = 1'b0;
      TX_DATA:   tx_pin = tx_shift[0];
      TX_PARITY: tx_pin = tx_par;
      default:   tx_pin = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= 16'd2;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx_pin;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  assign rx_half_end = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);

  // START waits half a bit so every later sample lands mid-bit
  always_comb begin
    rx_state_n     = rx_state;
    rx_cnt_n       = rx_cnt;
    rx_div_n       = rx_div;
    rx_bit_n       = rx_bit;
    rx_shift_n     = rx_shift;
    rx_push        = 1'b0;
    set_overrun    = 1'b0;
    set_frame_err  = 1'b0;
    set_parity_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_cnt_n   = '0;
          rx_div_n   = divisor;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_n = rx_cnt + 16'd1;
        if (rx_half_end) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_n = rx_cnt + 16'd1;
        if (rx_bit_end) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end
        end
      end
      RX_PARITY: begin
        rx_cnt_n = rx_cnt + 16'd1;
        if (rx_bit_end) begin
          rx_cnt_n       = '0;
          set_parity_err = (rx_s2 != ^rx_shift);
          rx_state_n     = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_n = rx_cnt + 16'd1;
        if (rx_bit_end) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (!rx_s2)       set_frame_err = 1'b1;
          else if (rx_full) set_overrun   = 1'b1;
          else              rx_push       = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata[7:0] = rx_head;
      2'd1: begin
        rdata[0]     = !rx_empty;
        rdata[1]     = rx_full;
        rdata[2]     = tx_empty;
        rdata[3]     = tx_full;
        rdata[4]     = rx_overrun;
        rdata[5]     = frame_err;
        rdata[6]     = (tx_state != TX_IDLE);
        rdata[7]     = parity_err;
        rdata[15:8]  = 8'(rx_count);
        rdata[23:16] = 8'(tx_count);
      end
      2'd2:    rdata[1:0] = {ctrl_tx_irq, ctrl_rx_irq};
      default: rdata[15:0] = divisor;
    endcase
  end

  assign ReadData_o = DATA_WIDTH'(rdata);
  assign irq_o = (ctrl_rx_irq & !rx_empty) | (ctrl_tx_irq & tx_empty)
               | rx_overrun | frame_err | parity_err;

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed/randomized bench for mmio_uart_fifo with a queue-based reference model.
// Runs the default 8N1 build at divisor 4 after the reset-value checks.
module tb_mmio_uart_fifo;

  localparam int          DEPTH = 8;
  localparam int          DIV   = 4;
  localparam logic [31:0] BASE  = 32'h1001_0020;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;
  localparam logic [31:0] A_DIVR = BASE + 32'd12;

  logic        clk, reset;
  logic [31:0] Address_i, WriteData_i, ReadData_o;
  logic        MemWrite_i, MemRead_i, Hit_o, rx_pin, tx_pin, irq_o;

  int          checks, errors;
  logic [31:0] rd;
  int          waited, lows;
  logic [7:0]  b;
  logic [7:0]  burst [10];
  logic [7:0]  rx_model [$];
  bit          ovr_m, ferr_m;

  mmio_uart_fifo #(
    .DATA_WIDTH(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(434)
  ) dut (
    .clk(clk), .reset(reset), .Address_i(Address_i), .WriteData_i(WriteData_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .ReadData_o(ReadData_o),
    .Hit_o(Hit_o), .rx_pin(rx_pin), .tx_pin(tx_pin), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Bus write: strobe is sampled by the posedge between the two negedges
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address_i = addr; WriteData_i = data; MemWrite_i = 1'b1;
    @(negedge clk);
    MemWrite_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic pop, output logic [31:0] data);
    @(negedge clk);
    Address_i = addr; MemRead_i = pop;
    #1 data = ReadData_o;
    @(negedge clk);
    MemRead_i = 1'b0;
  endtask

  function automatic logic [31:0] exp_status(int rx_n, int tx_n, bit ovr, bit ferr, bit busy);
    logic [31:0] s;
    s = '0;
    s[0] = (rx_n > 0);
    s[1] = (rx_n == DEPTH);
    s[2] = (tx_n == 0);
    s[3] = (tx_n == DEPTH);
    s[4] = ovr;
    s[5] = ferr;
    s[6] = busy;
    s[15:8]  = rx_n[7:0];
    s[23:16] = tx_n[7:0];
    return s;
  endfunction

  // Serial frame into rx_pin, then a quiet gap of three bit times
  task automatic send_rx(input logic [7:0] data, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx_pin = 1'b1;
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic model_rx(input logic [7:0] data, input logic stop_bit);
    send_rx(data, stop_bit);
    if (!stop_bit) ferr_m = 1'b1;
    else if (rx_model.size() == DEPTH) ovr_m = 1'b1;
    else rx_model.push_back(data);
  endtask

  // Waits for a start bit, then samples first and last clock of each of the 10 bits
  task automatic check_tx_frame(input logic [7:0] data, output int n);
    logic [9:0] first_s, last_s, exp_f;
    first_s = '0; last_s = '0;
    n = 0;
    while (tx_pin !== 1'b0 && n < 30 * DIV + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_start", {31'b0, tx_pin}, 32'd0);
    if (tx_pin === 1'b0) begin
      exp_f = {1'b1, data, 1'b0};
      for (int k = 0; k < 10 * DIV; k++) begin
        if (k % DIV == 0)       first_s[k / DIV] = tx_pin;
        if (k % DIV == DIV - 1) last_s[k / DIV]  = tx_pin;
        @(negedge clk);
      end
      checkOutput("tx_frame_first", {22'b0, first_s}, {22'b0, exp_f});
      checkOutput("tx_frame_last",  {22'b0, last_s},  {22'b0, exp_f});
    end
  endtask

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Address_i = A_DATA; WriteData_i = {24'h0, burst[i]}; MemWrite_i = 1'b1;
    end
    @(negedge clk);
    MemWrite_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; ovr_m = 0; ferr_m = 0;
    reset = 1'b1; Address_i = A_STAT; WriteData_i = '0;
    MemWrite_i = 1'b0; MemRead_i = 1'b0; rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_tx_pin", {31'b0, tx_pin}, 32'd1);
    checkOutput("reset_irq", {31'b0, irq_o}, 32'd0);
    bus_read(A_STAT, 1'b0, rd); checkOutput("reset_status", rd, 32'h0000_0004);
    bus_read(A_DIVR, 1'b0, rd); checkOutput("reset_divisor", rd, 32'd434);
    bus_read(A_CTRL, 1'b0, rd); checkOutput("reset_ctrl", rd, 32'd0);
    bus_read(A_DATA, 1'b1, rd); checkOutput("empty_rx_read", rd, 32'd0);

    @(negedge clk); Address_i = BASE + 32'h10;
    #1 checkOutput("hit_outside", {31'b0, Hit_o}, 32'd0);
    Address_i = A_DIVR;
    #1 checkOutput("hit_inside", {31'b0, Hit_o}, 32'd1);

    applyStimulus(A_DIVR, 32'd1);
    bus_read(A_DIVR, 1'b0, rd); checkOutput("divisor_clamp", rd, 32'd2);
    applyStimulus(A_DIVR, DIV);
    applyStimulus(BASE + 32'h1C, 32'd9);
    bus_read(A_DIVR, 1'b0, rd); checkOutput("divisor_miss_ignored", rd, DIV);

    // Single byte: start bit one clock after the push edge, 10 bits of DIV clocks
    applyStimulus(A_DATA, 32'h55);
    checkOutput("tx_idle_after_push", {31'b0, tx_pin}, 32'd1);
    check_tx_frame(8'h55, waited);
    checkOutput("tx_latency", waited, 32'd1);
    bus_read(A_STAT, 1'b0, rd); checkOutput("tx_done_status", rd, exp_status(0, 0, 0, 0, 0));

    // Ten back-to-back pushes: one goes straight to the engine, eight queue, the last drops
    for (int i = 0; i < 10; i++) burst[i] = 8'($urandom_range(0, 255));
    fork
      begin
        push_burst(10);
        bus_read(A_STAT, 1'b0, rd);
        checkOutput("tx_full_status", rd, exp_status(0, DEPTH, 0, 0, 1));
      end
      begin
        for (int i = 0; i < 9; i++) check_tx_frame(burst[i], waited);
      end
    join
    lows = 0;
    for (int k = 0; k < 15 * DIV; k++) begin
      @(negedge clk);
      if (tx_pin === 1'b0) lows++;
    end
    checkOutput("tx_no_tenth_frame", lows, 32'd0);

    send_rx(8'hA3, 1'b1);
    bus_read(A_STAT, 1'b0, rd); checkOutput("rx_one_status", rd, exp_status(1, 0, 0, 0, 0));
    bus_read(A_DATA, 1'b0, rd); checkOutput("rx_peek", rd, 32'hA3);
    bus_read(A_DATA, 1'b1, rd); checkOutput("rx_pop", rd, 32'hA3);
    bus_read(A_STAT, 1'b0, rd); checkOutput("rx_popped_status", rd, exp_status(0, 0, 0, 0, 0));
    bus_read(A_DATA, 1'b1, rd); checkOutput("rx_second_read", rd, 32'd0);

    for (int i = 0; i < 9; i++) model_rx(8'($urandom_range(0, 255)), 1'b1);
    bus_read(A_STAT, 1'b0, rd);
    checkOutput("rx_overrun_status", rd, exp_status(rx_model.size(), 0, ovr_m, ferr_m, 0));
    checkOutput("rx_overrun_irq", {31'b0, irq_o}, 32'd1);
    applyStimulus(A_CTRL, 32'h4); ovr_m = 0;
    bus_read(A_STAT, 1'b0, rd);
    checkOutput("rx_cleared_status", rd, exp_status(rx_model.size(), 0, ovr_m, ferr_m, 0));
    checkOutput("irq_after_clear", {31'b0, irq_o}, 32'd0);
    applyStimulus(A_CTRL, 32'h1);
    bus_read(A_CTRL, 1'b0, rd); checkOutput("ctrl_readback", rd, 32'h1);
    checkOutput("irq_rx_enabled", {31'b0, irq_o}, 32'd1);
    while (rx_model.size() > 0) begin
      bus_read(A_DATA, 1'b1, rd);
      checkOutput("rx_fifo_data", rd, {24'h0, rx_model.pop_front()});
    end
    checkOutput("irq_rx_drained", {31'b0, irq_o}, 32'd0);
    applyStimulus(A_CTRL, 32'h2);
    checkOutput("irq_tx_empty", {31'b0, irq_o}, 32'd1);
    applyStimulus(A_CTRL, 32'h0);

    model_rx(8'($urandom_range(0, 255)), 1'b0);
    bus_read(A_STAT, 1'b0, rd);
    checkOutput("frame_err_status", rd, exp_status(rx_model.size(), 0, ovr_m, ferr_m, 0));
    checkOutput("frame_err_irq", {31'b0, irq_o}, 32'd1);
    applyStimulus(A_CTRL, 32'h4); ferr_m = 0;

    @(negedge clk); rx_pin = 1'b0;
    @(negedge clk); rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_STAT, 1'b0, rd); checkOutput("glitch_ignored", rd, exp_status(0, 0, 0, 0, 0));
    b = 8'($urandom_range(0, 255));
    model_rx(b, 1'b1);
    bus_read(A_DATA, 1'b1, rd); checkOutput("rx_after_glitch", rd, {24'h0, rx_model.pop_front()});

    model_rx(8'($urandom_range(0, 255)), 1'b1);
    model_rx(8'($urandom_range(0, 255)), 1'b1);
    bus_read(A_STAT, 1'b0, rd);
    checkOutput("pre_flush_status", rd, exp_status(rx_model.size(), 0, 0, 0, 0));
    applyStimulus(A_CTRL, 32'h8); rx_model.delete();
    bus_read(A_STAT, 1'b0, rd); checkOutput("flush_status", rd, exp_status(0, 0, 0, 0, 0));
    bus_read(A_CTRL, 1'b0, rd); checkOutput("flush_ctrl_reads_0", rd, 32'd0);

    // Reset in the middle of an all-zero data field must raise tx_pin on the next edge
    applyStimulus(A_DATA, 32'h00);
    repeat (2 * DIV + 2) @(negedge clk);
    checkOutput("tx_mid_frame_low", {31'b0, tx_pin}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_abort_tx_pin", {31'b0, tx_pin}, 32'd1);
    reset = 1'b0;
    bus_read(A_DIVR, 1'b0, rd); checkOutput("reset_divisor_again", rd, 32'd434);
    bus_read(A_STAT, 1'b0, rd); checkOutput("reset_status_again", rd, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_fifo.md
# mmio_uart_fifo

Memory-mapped, buffered UART peripheral for the multicycle RISC-V core. It replaces the separate start, data, ready and clear registers with one block on the core data bus. The block holds TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and an interrupt line. Software streams bytes without polling each one, and no receive data is lost while the core is busy.

## Interface
- `DATA_WIDTH`, 32, bus data/address width (≥16)
- `BASE_ADDR`, 32'h1001_0020, word-aligned base of the 16-byte register window
- `FIFO_DEPTH`, 8, entries per FIFO; power of two, 2..256
- `CLKS_PER_BIT`, 434, reset value of DIVISOR (50 MHz / 115200)
- `clk`  in  1  single clock; one clock domain for bus, FIFOs and UART engines
- `reset`  in  1  synchronous, active-high
- `Address_i`  in  DATA_WIDTH  byte address from core
- `WriteData_i`  in  DATA_WIDTH  store data
- `MemWrite_i`  in  1  store strobe, one cycle
- `MemRead_i`  in  1  load strobe, one cycle; needed for RX pop side effect
- `ReadData_o`  out  DATA_WIDTH  load data, combinational from Address_i
- `Hit_o`  out  1  Address_i[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]
- `rx_pin`  in  1  asynchronous serial input, idle high
- `tx_pin`  out  1  serial output, idle high
- `irq_o`  out  1  level interrupt

## Operation
- Register offsets use `Address_i[3:2]`.
  - 0 DATA: a write pushes `WriteData_i[7:0]` into the TX FIFO. A read returns `{0, rx_head[7:0]}`; a read with `MemRead_i` pops.
  - 1 STATUS (read-only):
    - b0 rx_not_empty, b1 rx_full, b2 tx_empty, b3 tx_full
    - b4 rx_overrun, b5 frame_err (b4–b5 sticky)
    - b6 tx_busy
    - [15:8] rx_count, [23:16] tx_count
  - 2 CTRL:
    - b0 rx_irq_en, b1 tx_irq_en (read/write)
    - b2 write-1 clears sticky flags
    - b3 write-1 flushes both FIFOs
    - b2/b3 read back 0
  - 3 DIVISOR: [15:0] clocks per bit. Writes below 2 clamp to 2.
- Writes and pops act only when `Hit_o`=1.
- A read of an empty RX FIFO returns 0 and leaves the pointers unchanged.
- A push into a full TX FIFO is dropped silently.
- A push and a pop on the same FIFO in the same cycle both take effect; the count is unchanged.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops the head and latches the divisor.
  - Each state holds for `divisor` clocks.
- RX path:
  - 2-flop synchronizer.
  - FSM: IDLE → START → DATA → STOP.
  - A falling edge in IDLE starts a frame. START re-checks the line at divisor/2; a high sample returns to IDLE (glitch).
  - Data bits are sampled mid-bit.
  - In STOP, a sampled 0 sets frame_err and discards the byte.
  - A valid byte arriving with the RX FIFO full is discarded and sets rx_overrun.
- `irq_o` = (rx_irq_en & rx_not_empty) | (tx_irq_en & tx_empty) | rx_overrun | frame_err.
- Flush clears the FIFO pointers only. A frame already in progress on either engine completes; a completed RX frame then enters the empty FIFO.

## Timing
- Reset values:
  - `tx_pin`=1, `irq_o`=0, `ReadData_o` = f(Address_i)
  - FIFOs empty, CTRL=0, DIVISOR=`CLKS_PER_BIT`
  - both FSMs IDLE, sticky flags 0
- Register writes and pops take effect on the `clk` edge that samples the strobe; STATUS reflects them the next cycle.
- TX latency: the start bit begins 1 clk after the push edge when the engine is IDLE.
- Frame length: 10 × divisor clks (11 with parity).
- RX: the byte is visible in the FIFO 1 clk after the mid-stop-bit sample.
- A divisor write mid-frame applies from the next frame only. RX latches its divisor at start detection.
- Reset mid-frame aborts immediately: `tx_pin`=1 on the next edge and the partial RX byte is dropped.

## Configuration
- `MMIO_UART_PARITY_EN`
  - **Defined:** one even-parity bit is inserted after the data bits on TX and checked on RX. A mismatch sets sticky STATUS b7 parity_err, which ORs into `irq_o`; the byte is still stored.
  - **Undefined:** the frame is 8N1 and b7 reads 0.

## Test plan
- Reset, DIVISOR=4, write DATA=0x55 → `tx_pin` shows start, then 1,0,1,0,1,0,1,0, then stop; 4 clks per bit, 40 clks total; tx_busy clears afterwards.
- Drive 0xA3 on `rx_pin` at divisor 4 → STATUS rx_count=1; DATA read returns 0xA3; rx_count=0 after the pop; a second read returns 0.
- Push 10 bytes with FIFO_DEPTH=8 while TX is idle → the first byte starts immediately, 8 are queued, the 10th is dropped; exactly 9 frames appear on `tx_pin`.
- Receive 9 bytes without popping → rx_full=1, rx_overrun=1, `irq_o`=1, the first 8 bytes are intact; CTRL write 0x4 clears rx_overrun.
- Stop bit driven 0 → frame_err=1 and the FIFO stays empty; a 1-clk low glitch on `rx_pin` is ignored.
- Assert `reset` mid-TX frame → `tx_pin`=1 next cycle, DIVISOR reads 434, STATUS reads 0x0000_0004.
